// File: rtl/i2c_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_arbiter_if
// Purpose  : Bundles the requester command/response handshake and the
//            i2c_master control/status signals that the arbiter sits between.
// Ports    : req_*        per-requester command handshake (packed per requester)
//            rsp_*        one-hot completion pulse with shared data/status
//            m_*          connection to the shared i2c_master instance
// Modports : slave  - the arbiter itself
//            master - the system side (requesters and the i2c_master)
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [7*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]   req_rw;
  logic [8*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]   rsp_valid;
  logic [7:0]         rsp_data;
  logic [1:0]         rsp_status;
  logic               m_start;
  logic [6:0]         m_addr;
  logic               m_rw;
  logic [7:0]         m_data_w;
  logic               m_busy;
  logic               m_valid_out;
  logic [7:0]         m_data_out;
  logic               m_erro_addr;

  modport slave (
    input  req_valid, req_addr, req_rw, req_wdata,
    input  m_busy, m_valid_out, m_data_out, m_erro_addr,
    output req_ready, rsp_valid, rsp_data, rsp_status,
    output m_start, m_addr, m_rw, m_data_w
  );

  modport master (
    output req_valid, req_addr, req_rw, req_wdata,
    output m_busy, m_valid_out, m_data_out, m_erro_addr,
    input  req_ready, rsp_valid, rsp_data, rsp_status,
    input  m_start, m_addr, m_rw, m_data_w
  );
endinterface
`default_nettype wire

// File: rtl/i2c_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_arbiter
// Purpose  : Round-robin arbiter and sequencer sharing one i2c_master among
//            N_REQ requesters. Accepts one command at a time, drives the
//            master, tracks it to completion and returns a one-cycle
//            response with status to the issuing requester.
// Ports    : clk  - clock
//            rst  - asynchronous active-high reset
//            bus  - i2c_arbiter_if.slave (requester handshake + master link)
// Status   : 00 OK, 01 NACK, 10 start timeout, 11 transfer timeout
// Revision : 1.0 - initial release
// ============================================================================
module i2c_arbiter #(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 16,
  parameter int XFER_TIMEOUT  = 65535
) (
  input  logic         clk,
  input  logic         rst,
  i2c_arbiter_if.slave bus
);

  localparam int CNT_MAX = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CW-1:0]    CNT_SAT    = CW'(CNT_MAX);
  localparam logic [CW-1:0]    START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0]    XFER_LAST  = CW'(XFER_TIMEOUT - 1);
  localparam logic [GW-1:0]    GRANT_RST  = GW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0   = {{(N_REQ-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_NACK     = 2'b01;
  localparam logic [1:0] ST_START_TO = 2'b10;
  localparam logic [1:0] ST_XFER_TO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_RUN   = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           r_state;
  logic [GW-1:0]    r_last_grant;
  logic [CW-1:0]    r_cnt;
  logic [6:0]       r_addr;
  logic             r_rw;
  logic [7:0]       r_wdata;
  logic [7:0]       r_rbuf;
  logic             r_nack;
  logic             r_drain;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [7:0]       r_rsp_data;
  logic [1:0]       r_rsp_status;

  logic [GW-1:0]    w_winner;
  logic [GW-1:0]    w_idx;
  logic             w_found;
  logic             w_grant;
  logic [CW-1:0]    w_cnt_inc;
  logic [7:0]       w_rbuf_next;
  logic             w_nack_next;

  // Rotating priority: scan from the requester after the last winner.
  always_comb begin
    w_winner = r_last_grant;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = GW'((int'(r_last_grant) + k) % N_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  // rst gates the grant so req_ready is zero while reset is held.
  assign w_grant       = !rst && (r_state == S_IDLE) && !bus.m_busy && w_found;
  assign bus.req_ready = w_grant ? (ONE_HOT0 << w_winner) : '0;

  // Saturating counter shared by the start and transfer timeouts.
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);

  // Data/nack arriving together with busy falling must still count.
  assign w_rbuf_next = bus.m_valid_out ? bus.m_data_out : r_rbuf;
  assign w_nack_next = r_nack | bus.m_erro_addr;

  // Start must drop in the very cycle busy is seen, hence combinational.
  assign bus.m_start    = (r_state == S_ISSUE) && !bus.m_busy;
  assign bus.m_addr     = r_addr;
  assign bus.m_rw       = r_rw;
  assign bus.m_data_w   = r_wdata;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_status = r_rsp_status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= GRANT_RST;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_rw         <= 1'b0;
      r_wdata      <= '0;
      r_rbuf       <= '0;
      r_nack       <= 1'b0;
      r_drain      <= 1'b0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_addr       <= bus.req_addr[int'(w_winner)*7 +: 7];
            r_rw         <= bus.req_rw[w_winner];
            r_wdata      <= bus.req_wdata[int'(w_winner)*8 +: 8];
            r_last_grant <= w_winner;
            r_cnt        <= '0;
            r_drain      <= 1'b0;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.m_busy) begin
            r_cnt   <= '0;
            r_nack  <= 1'b0;
            r_rbuf  <= '0;
            r_state <= S_RUN;
          end else if (r_cnt == START_LAST) begin
            r_rsp_status <= ST_START_TO;
            r_rsp_data   <= '0;
            r_rsp_valid  <= ONE_HOT0 << r_last_grant;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RUN: begin
          r_rbuf <= w_rbuf_next;
          r_nack <= w_nack_next;
          if (!bus.m_busy) begin
            r_rsp_status <= w_nack_next ? ST_NACK : ST_OK;
            r_rsp_data   <= (!w_nack_next && r_rw) ? w_rbuf_next : 8'h00;
            r_rsp_valid  <= ONE_HOT0 << r_last_grant;
            r_state      <= S_RESP;
          end else if (r_cnt == XFER_LAST) begin
            // Master is still busy: respond now, then wait it out in DRAIN.
            r_rsp_status <= ST_XFER_TO;
            r_rsp_data   <= '0;
            r_rsp_valid  <= ONE_HOT0 << r_last_grant;
            r_drain      <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESP: begin
          r_state <= r_drain ? S_DRAIN : S_IDLE;
        end
        S_DRAIN: begin
          if (!bus.m_busy) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_arbiter
// Purpose  : Self-checking bench for i2c_arbiter with a behavioural
//            i2c_master model and a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  i2c_arbiter_if #(.N_REQ(N)) bus ();

  i2c_arbiter #(
    .N_REQ         (N),
    .START_TIMEOUT (16),
    .XFER_TIMEOUT  (65535)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural i2c_master ----------------
  int         cfg_len    = 3;
  bit         cfg_nack   = 1'b0;
  bit         cfg_late   = 1'b0;
  bit         cfg_noresp = 1'b0;
  logic [7:0] cfg_rdata  = 8'h00;

  int         mdl_left;
  bit         cap_late, cap_nack, cap_rw;
  logic [7:0] cap_rdata;

  // busy rises the cycle after start is seen and stays high cfg_len cycles;
  // result pulses land in the last busy cycle or (late) the first idle one.
  always @(posedge clk) begin
    bus.m_valid_out <= 1'b0;
    bus.m_erro_addr <= 1'b0;
    if (rst) begin
      bus.m_busy     <= 1'b0;
      bus.m_data_out <= 8'h00;
      mdl_left       <= 0;
    end else if (!bus.m_busy) begin
      if (bus.m_start && !cfg_noresp) begin
        bus.m_busy <= 1'b1;
        mdl_left   <= cfg_len;
        cap_late   <= cfg_late;
        cap_nack   <= cfg_nack;
        cap_rw     <= bus.m_rw;
        cap_rdata  <= cfg_rdata;
      end
    end else begin
      mdl_left <= mdl_left - 1;
      if (mdl_left == 1) bus.m_busy <= 1'b0;
      if ((mdl_left == 2 && !cap_late) || (mdl_left == 1 && cap_late)) begin
        if (cap_nack) bus.m_erro_addr <= 1'b1;
        if (cap_rw) begin
          bus.m_valid_out <= 1'b1;
          bus.m_data_out  <= cap_nack ? 8'hFF : cap_rdata;
        end
      end
    end
  end

  // ---------------- requester fields + reference model ----------------
  logic [6:0] fld_addr [N];
  logic       fld_rw   [N];
  logic [7:0] fld_wd   [N];
  int         model_last;

  task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    fld_addr[i] = a;
    fld_rw[i]   = rw;
    fld_wd[i]   = wd;
    bus.req_addr[7*i +: 7]  = a;
    bus.req_rw[i]           = rw;
    bus.req_wdata[8*i +: 8] = wd;
  endtask

  function automatic int rr_pick(input logic [3:0] m, input int last);
    int c;
    rr_pick = -1;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (rr_pick < 0 && m[c[1:0]]) rr_pick = c;
    end
  endfunction

  typedef struct {
    int         gnt;
    logic [3:0] rdy;
    int         wait_c;
    logic [3:0] rv;
    logic [1:0] st;
    logic [7:0] rd;
    int         nstart;
    int         lat;
    int         extra;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wd;
    bit         tmo;
  } txn_t;

  // Drives one command and observes it to the response; called just after a
  // negedge, returns during the response cycle. lat counts from grant cycle.
  task automatic do_txn(input logic [3:0] mask, input bit keep, output txn_t r);
    r = '{gnt: -1, rdy: '0, wait_c: 0, rv: '0, st: '0, rd: '0, nstart: 0,
          lat: 0, extra: 0, addr: '0, rw: 1'b0, wd: '0, tmo: 1'b0};
    bus.req_valid = mask;
    #1;
    while (bus.req_ready == '0 && r.wait_c < 10000) begin
      @(negedge clk); #1; r.wait_c++;
    end
    if (bus.req_ready == '0) begin
      r.tmo = 1'b1;
    end else begin
      r.rdy = bus.req_ready;
      for (int k = 0; k < N; k++) if (r.gnt < 0 && r.rdy[k]) r.gnt = k;
      @(negedge clk);
      if (!keep) bus.req_valid = '0;
      #1;
      r.addr = bus.m_addr;
      r.rw   = bus.m_rw;
      r.wd   = bus.m_data_w;
      r.lat  = 1;
      while (bus.rsp_valid == '0 && r.lat < 80000) begin
        if (bus.m_start) r.nstart++;
        if (bus.req_ready != '0) r.extra++;
        @(negedge clk); #1; r.lat++;
      end
      if (bus.rsp_valid == '0) r.tmo = 1'b1;
      r.rv = bus.rsp_valid;
      r.st = bus.rsp_status;
      r.rd = bus.rsp_data;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_last = N - 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    for (int i = 0; i < N; i++) set_req(i, 7'h55, 1'b1, 8'hC3);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 4'h0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    checks++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_status} !== 14'h0) begin failures++; $display("FAIL reset_rsp got=%b/%h/%b exp=0", bus.rsp_valid, bus.rsp_data, bus.rsp_status); end
    checks++; if ({bus.m_start, bus.m_addr, bus.m_rw, bus.m_data_w} !== 17'h0) begin failures++; $display("FAIL reset_master got=%b/%h/%b/%h exp=0", bus.m_start, bus.m_addr, bus.m_rw, bus.m_data_w); end
    bus.req_valid = 4'h0;
    rst = 1'b0;
    model_last = N - 1;
    @(negedge clk);
  endtask

  task automatic test_write();
    txn_t r;
    set_req(1, 7'h50, 1'b0, 8'hA5);
    cfg_len = 4; cfg_nack = 0; cfg_late = 0; cfg_rdata = 8'h99;
    do_txn(4'b0010, 1'b0, r);
    model_last = 1;
    checks++; if (r.tmo !== 1'b0) begin failures++; $display("FAIL write_timeout got=%0d exp=0", r.tmo); end
    checks++; if (r.gnt !== 1) begin failures++; $display("FAIL write_gnt got=%0d exp=1", r.gnt); end
    checks++; if ({r.addr, r.rw, r.wd} !== {7'h50, 1'b0, 8'hA5}) begin failures++; $display("FAIL write_cmd got=%h/%b/%h exp=50/0/a5", r.addr, r.rw, r.wd); end
    checks++; if (r.nstart !== 1) begin failures++; $display("FAIL write_nstart got=%0d exp=1", r.nstart); end
    checks++; if ({r.rv, r.st, r.rd} !== {4'b0010, 2'b00, 8'h00}) begin failures++; $display("FAIL write_rsp got=%b/%b/%h exp=0010/00/00", r.rv, r.st, r.rd); end
    checks++; if (r.lat !== 7) begin failures++; $display("FAIL write_latency got=%0d exp=7", r.lat); end
  endtask

  task automatic test_read();
    txn_t r;
    set_req(0, 7'h3C, 1'b1, 8'h00);
    cfg_len = 5; cfg_nack = 0; cfg_late = 1; cfg_rdata = 8'h5E;
    do_txn(4'b0001, 1'b0, r);
    model_last = 0;
    checks++; if (r.gnt !== 0) begin failures++; $display("FAIL read_gnt got=%0d exp=0", r.gnt); end
    checks++; if ({r.rv, r.st, r.rd} !== {4'b0001, 2'b00, 8'h5E}) begin failures++; $display("FAIL read_rsp got=%b/%b/%h exp=0001/00/5e", r.rv, r.st, r.rd); end
    checks++; if (r.lat !== 8) begin failures++; $display("FAIL read_latency got=%0d exp=8", r.lat); end
  endtask

  task automatic test_nack();
    txn_t r;
    set_req(2, 7'h12, 1'b1, 8'h00);
    cfg_len = 3; cfg_nack = 1; cfg_late = 0; cfg_rdata = 8'h77;
    do_txn(4'b0100, 1'b0, r);
    model_last = 2;
    cfg_nack = 0;
    checks++; if ({r.rv, r.st, r.rd} !== {4'b0100, 2'b01, 8'h00}) begin failures++; $display("FAIL nack_rsp got=%b/%b/%h exp=0100/01/00", r.rv, r.st, r.rd); end
    @(negedge clk); #1;
    checks++; if ({bus.rsp_valid, bus.rsp_status} !== {4'b0000, 2'b01}) begin failures++; $display("FAIL nack_hold got=%b/%b exp=0000/01", bus.rsp_valid, bus.rsp_status); end
  endtask

  task automatic test_reset_mid_run();
    txn_t r;
    int   wc;
    set_req(2, 7'h2A, 1'b1, 8'h77);
    cfg_len = 20; cfg_nack = 0; cfg_late = 0;
    bus.req_valid = 4'b0100;
    #1; wc = 0;
    while (bus.req_ready == '0 && wc < 50) begin @(negedge clk); #1; wc++; end
    checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL midrun_grant got=%b exp=0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'hF;
    repeat (4) @(negedge clk);
    #1;
    checks++; if ({bus.m_busy, bus.m_addr} !== {1'b1, 7'h2A}) begin failures++; $display("FAIL midrun_pre got=%b/%h exp=1/2a", bus.m_busy, bus.m_addr); end
    rst = 1'b1;
    #1;
    checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_status, bus.m_start, bus.m_addr, bus.m_rw, bus.m_data_w} !== 35'h0) begin
      failures++; $display("FAIL midrun_outputs got=%b/%b/%h/%b/%b/%h/%b/%h exp=0", bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_status, bus.m_start, bus.m_addr, bus.m_rw, bus.m_data_w);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last = N - 1;
    for (int i = 0; i < N; i++) set_req(i, 7'(7'h10 + i), 1'b0, 8'(8'h20 + i));
    cfg_len = 3;
    do_txn(4'hF, 1'b0, r);
    model_last = 0;
    checks++; if (r.gnt !== 0) begin failures++; $display("FAIL midrun_first_gnt got=%0d exp=0", r.gnt); end
    checks++; if ({r.rv, r.st} !== {4'b0001, 2'b00}) begin failures++; $display("FAIL midrun_after_rsp got=%b/%b exp=0001/00", r.rv, r.st); end
  endtask

  task automatic test_start_timeout();
    txn_t r;
    set_req(3, 7'h44, 1'b0, 8'h3A);
    cfg_noresp = 1;
    do_txn(4'b1000, 1'b0, r);
    cfg_noresp = 0;
    model_last = 3;
    checks++; if (r.nstart !== 16) begin failures++; $display("FAIL start_to_held got=%0d exp=16", r.nstart); end
    checks++; if (r.lat !== 17) begin failures++; $display("FAIL start_to_latency got=%0d exp=17", r.lat); end
    checks++; if ({r.rv, r.st, r.rd} !== {4'b1000, 2'b10, 8'h00}) begin failures++; $display("FAIL start_to_rsp got=%b/%b/%h exp=1000/10/00", r.rv, r.st, r.rd); end
    set_req(1, 7'h61, 1'b0, 8'h0F);
    cfg_len = 3;
    do_txn(4'b0010, 1'b0, r);
    model_last = 1;
    checks++; if ({r.gnt, r.rv, r.st} !== {32'd1, 4'b0010, 2'b00}) begin failures++; $display("FAIL start_to_next got=%0d/%b/%b exp=1/0010/00", r.gnt, r.rv, r.st); end
  endtask

  task automatic test_round_robin();
    txn_t r;
    int   exp;
    int   order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) set_req(i, 7'(7'h30 + i), 1'b0, 8'(8'h40 + i));
    bus.req_valid = 4'hF;
    apply_reset();
    cfg_len = 3;
    for (int t = 0; t < 5; t++) begin
      do_txn(4'hF, 1'b1, r);
      exp = rr_pick(4'hF, model_last);
      model_last = exp;
      checks++; if (r.gnt !== order[t] || r.gnt !== exp) begin failures++; $display("FAIL rr_gnt%0d got=%0d exp=%0d", t, r.gnt, order[t]); end
      checks++; if (r.rv !== 4'(1 << order[t])) begin failures++; $display("FAIL rr_rsp%0d got=%b exp=%b", t, r.rv, 4'(1 << order[t])); end
      checks++; if (r.nstart !== 1 || r.extra !== 0) begin failures++; $display("FAIL rr_single%0d got=starts %0d ready %0d exp=1/0", t, r.nstart, r.extra); end
      if (t > 0) begin
        checks++; if (r.wait_c !== 1) begin failures++; $display("FAIL rr_gap%0d got=%0d exp=1", t, r.wait_c); end
      end
    end
    bus.req_valid = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_random();
    txn_t       r;
    logic [3:0] mask;
    int         exp;
    int         len;
    bit         nk;
    logic [7:0] rdat;
    logic [7:0] exp_rd;
    for (int t = 0; t < 24; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) set_req(i, 7'($urandom), 1'($urandom), 8'($urandom));
      len  = $urandom_range(2, 7);
      nk   = ($urandom_range(0, 3) == 0);
      rdat = 8'($urandom);
      cfg_len = len; cfg_nack = nk; cfg_late = 1'($urandom); cfg_rdata = rdat;
      exp    = rr_pick(mask, model_last);
      exp_rd = (!nk && fld_rw[exp]) ? rdat : 8'h00;
      do_txn(mask, 1'b0, r);
      model_last = exp;
      checks++; if (r.tmo !== 1'b0 || r.gnt !== exp) begin failures++; $display("FAIL rand%0d_gnt got=%0d tmo=%0d exp=%0d", t, r.gnt, r.tmo, exp); end
      checks++; if ({r.addr, r.rw, r.wd} !== {fld_addr[exp], fld_rw[exp], fld_wd[exp]}) begin failures++; $display("FAIL rand%0d_cmd got=%h/%b/%h exp=%h/%b/%h", t, r.addr, r.rw, r.wd, fld_addr[exp], fld_rw[exp], fld_wd[exp]); end
      checks++; if ({r.rv, r.st, r.rd} !== {4'(1 << exp), (nk ? 2'b01 : 2'b00), exp_rd}) begin failures++; $display("FAIL rand%0d_rsp got=%b/%b/%h exp=%b/%b/%h", t, r.rv, r.st, r.rd, 4'(1 << exp), (nk ? 2'b01 : 2'b00), exp_rd); end
      checks++; if (r.lat !== len + 3 || r.nstart !== 1) begin failures++; $display("FAIL rand%0d_timing got=lat %0d starts %0d exp=%0d/1", t, r.lat, r.nstart, len + 3); end
    end
    cfg_nack = 0;
  endtask

  task automatic test_xfer_timeout();
    txn_t r;
    set_req(0, 7'h0B, 1'b1, 8'h00);
    cfg_len = 70000; cfg_nack = 0; cfg_late = 0;
    do_txn(4'b0001, 1'b0, r);
    model_last = 0;
    checks++; if ({r.rv, r.st, r.rd} !== {4'b0001, 2'b11, 8'h00}) begin failures++; $display("FAIL xfer_to_rsp got=%b/%b/%h exp=0001/11/00", r.rv, r.st, r.rd); end
    checks++; if (r.lat !== 65538) begin failures++; $display("FAIL xfer_to_latency got=%0d exp=65538", r.lat); end
    set_req(1, 7'h22, 1'b0, 8'h81);
    cfg_len = 3;
    do_txn(4'b0010, 1'b0, r);
    model_last = 1;
    checks++; if (r.wait_c !== 4465) begin failures++; $display("FAIL xfer_drain_wait got=%0d exp=4465", r.wait_c); end
    checks++; if ({r.gnt, r.rv, r.st} !== {32'd1, 4'b0010, 2'b00}) begin failures++; $display("FAIL xfer_drain_next got=%0d/%b/%b exp=1/0010/00", r.gnt, r.rv, r.st); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_reset_mid_run();
    test_start_timeout();
    test_round_robin();
    test_random();
    test_xfer_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=no completion exp=bench finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/i2c_arbiter.md
# i2c_arbiter

Round-robin arbiter and sequencer that shares a single `i2c_master` between `N_REQ` independent requesters. It accepts one command at a time over a valid/ready handshake and drives the master's `start/addr/rw/data_w` inputs. It then tracks the master's `busy`, `valid_out` and `erro_addr` outputs to completion and returns a one-cycle response, with status, to the requester that issued the command. It sits between the system-side register/command logic and the `i2c_master` instance.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `START_TIMEOUT`, 16: max cycles `m_start` is held waiting for `m_busy` to rise.
- `XFER_TIMEOUT`, 65535: max cycles `m_busy` may stay high for one transfer.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in N_REQ: per-requester command valid.
- `req_ready` out N_REQ: per-requester accept; combinational, one-hot or zero.
- `req_addr` in 7·N_REQ: packed 7-bit slave addresses; requester i uses bits [7i+6:7i].
- `req_rw` in N_REQ: 1 = read, 0 = write.
- `req_wdata` in 8·N_REQ: packed write bytes.
- `rsp_valid` out N_REQ: one-cycle completion pulse, one-hot.
- `rsp_data` out 8: read byte; 0 for writes and for failed transfers.
- `rsp_status` out 2: 00 OK, 01 NACK, 10 start timeout, 11 transfer timeout.
- `m_start` out 1: to master `start`.
- `m_addr` out 7: to master `addr`.
- `m_rw` out 1: to master `rw`.
- `m_data_w` out 8: to master `data_w`.
- `m_busy` in 1: from master `busy`.
- `m_valid_out` in 1: from master `valid_out`.
- `m_data_out` in 8: from master `data_out`.
- `m_erro_addr` in 1: from master `erro_addr`.

## Operation
- States: IDLE, ISSUE, RUN, RESP, DRAIN.
- **IDLE.**
  - If `m_busy`=0 and any `req_valid` is high, the winner is the first set bit searching from `last_grant+1` upward, wrapping modulo N_REQ.
  - `req_ready[winner]`=1 in that same cycle.
  - On handshake: latch addr/rw/wdata into command registers, set `last_grant`=winner, clear the timeout counter, go to ISSUE.
  - If `m_busy`=1, no grant is made.
- **ISSUE.**
  - `m_start`=1 and the counter increments each cycle.
  - If `m_busy`=1 is sampled: `m_start`=0 in the same cycle, clear the counter, clear the sticky nack flag and read buffer, go to RUN.
  - If the counter reaches START_TIMEOUT: status 10, go to RESP.
- **RUN.**
  - `m_start`=0 and the counter increments.
  - `m_valid_out`=1 → latch `m_data_out` into the read buffer.
  - `m_erro_addr`=1 → set the sticky nack flag.
  - `m_busy`=0 → status 01 if nack else 00, go to RESP.
  - If the counter reaches XFER_TIMEOUT while `m_busy`=1: status 11, go to RESP with a pending drain.
- **RESP.**
  - `rsp_valid[last_grant]`=1 for exactly one cycle.
  - `rsp_data` = read buffer if status 00 and rw=1, else 0.
  - Then go to DRAIN if the drain is pending, else IDLE.
- **DRAIN.** Wait for `m_busy`=0, then go to IDLE. No grants and no start are issued here.
- `m_addr/m_rw/m_data_w` are driven from the command registers continuously from ISSUE until the next grant.
- `rsp_data/rsp_status` hold their values until the next RESP.
- A requester must hold `req_valid` and its fields stable until `req_ready`. Deasserting `req_valid` before grant withdraws the request.
- Reset, at any time including mid-transfer:
  - State → IDLE; `last_grant` → N_REQ-1, so requester 0 has first priority.
  - All outputs → 0: `req_ready`, `rsp_valid`, `rsp_data`, `rsp_status`, `m_start`, `m_addr`, `m_rw`, `m_data_w`.
  - The master is reset by its own reset; no response is issued for the aborted command.

## Timing
- Grant handshake in cycle T → `m_start`=1 from T+1.
- With the standard master, `busy` rises at T+2, so `m_start` is high exactly one cycle.
- `m_busy` falling seen in cycle F → `rsp_valid` at F+1 → earliest next grant at F+2.
- Arbiter overhead per transfer: 3 cycles beyond the master's busy window.
- Start timeout: `rsp_valid` at T+1+START_TIMEOUT.
- Counters are `$clog2(max(START_TIMEOUT, XFER_TIMEOUT)+1)` bits and saturate; they never wrap.
- `m_valid_out` and `m_erro_addr` in the same cycle as `m_busy` falling are still captured.

## Test plan
- Single write, req 1, addr 0x50, wdata 0xA5, slave ACKs → `m_addr`=0x50, `m_rw`=0, `m_data_w`=0xA5, one `m_start` pulse; `rsp_valid`=0010, status 00, `rsp_data`=0x00.
- Read, req 0, addr 0x3C, slave returns 0x5E → `rsp_valid`=0001, status 00, `rsp_data`=0x5E, one cycle after busy falls.
- `req_valid`=1111 held from reset → grants in order 0, 1, 2, 3, 0. Each grant occurs only after the previous `rsp_valid` with `m_busy`=0, and at most one `m_start` is outstanding.
- Slave NACKs the address on req 2 → `m_erro_addr` pulse; `rsp_valid`=0100, status 01, `rsp_data`=0.
- Master model never raises busy → `m_start` held 16 cycles, then status 10; the next request is granted normally.
- Busy held 65535+ cycles → status 11, then no grant until busy falls. Separately, assert `rst` mid-RUN → all outputs 0 immediately; after release, requester 0 wins first.
